// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl_pkg.sv
// Shared types and constants for the active-low-set latch write/set sequencer.
package gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl_pkg;

  localparam int CNT_W = 4;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_SET   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SETLOW = 3'd4,
    ST_RECOV  = 3'd5
  } state_e;

  // Phase lengths must fit the 4-bit down-counter without wrapping.
  function automatic logic cyc_ok(input int c);
    return (c >= 1) && (c <= 15);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl_cnt.sv
// 4-bit loadable down-counter with a zero flag; holds at zero instead of wrapping.
module gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl_cnt
  import gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl_pkg::*;
(
  input  logic             CLK,
  input  logic             RN,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl.sv
// Replays write/set requests as timed D/E/SETN pin sequences for a bank of active-low-set latches.
module gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl
  import gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int SETW_CYC  = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             REQ_VALID,
  input  logic             REQ_SET,
  input  logic [WIDTH-1:0] REQ_DATA,
  output logic             REQ_READY,
  output logic [WIDTH-1:0] LAT_D,
  output logic             LAT_E,
  output logic             LAT_SETN,
  output logic             BUSY,
  output logic             DONE,
  output state_e           DBG_STATE
);

  if (!cyc_ok(SETUP_CYC) || !cyc_ok(PULSE_CYC) || !cyc_ok(HOLD_CYC) ||
      !cyc_ok(SETW_CYC) || !cyc_ok(RECOV_CYC)) begin : g_param_err
    $fatal(1, "latsnq_wrctl: every *_CYC parameter must be in 1..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETW_LD  = CNT_W'(SETW_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_e_q, lat_e_d;
  logic             lat_setn_q, lat_setn_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  gf180mcu_fd_sc_mcu9t5v0__latsnq_wrctl_cnt u_cnt (
    .CLK        (CLK),
    .RN         (RN),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Handshake: a request is accepted on a rising edge where REQ_VALID and
  // REQ_READY are both high; REQ_READY is high only in IDLE and nothing is queued.
  always_comb begin
    state_d    = state_q;
    lat_d_d    = lat_d_q;
    lat_e_d    = lat_e_q;
    lat_setn_d = lat_setn_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          cnt_load = 1'b1;
          case (REQ_SET)
            OP_WRITE: begin
              lat_d_d = REQ_DATA;
              cnt_val = SETUP_LD;
              state_d = ST_SETUP;
            end
            OP_SET: begin
              lat_setn_d = 1'b0;
              cnt_val    = SETW_LD;
              state_d    = ST_SETLOW;
            end
            default: ;
          endcase
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          lat_e_d  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = PULSE_LD;
          state_d  = ST_PULSE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          lat_e_d  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
          state_d  = ST_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SETLOW: begin
        if (cnt_zero) begin
          lat_setn_d = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = RECOV_LD;
          state_d    = ST_RECOV;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RECOV: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_IDLE;
      lat_d_q    <= '0;
      lat_e_q    <= 1'b0;
      lat_setn_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_d_q    <= lat_d_d;
      lat_e_q    <= lat_e_d;
      lat_setn_q <= lat_setn_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
    end
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign LAT_D     = lat_d_q;
  assign LAT_E     = lat_e_q;
  assign LAT_SETN  = lat_setn_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DBG_STATE = state_q;

endmodule
